// File: rtl/d_using_tff_pkg.sv
// Shared constants for the T-flip-flop based register library.
package d_using_tff_pkg;

   localparam logic RST_BIT_DEFAULT = 1'b0;

   // Toggle mask that makes a bank of T flip-flops land on a target value.
   function automatic logic toggle_for(input logic target, input logic current);
      return target ^ current;
   endfunction

endpackage

// File: rtl/d_using_tff_t_ff.sv
// Single T flip-flop with asynchronous active-low reset to a parameterised value.
module t_ff
   import d_using_tff_pkg::*;
#(
   parameter logic RESET_VAL = RST_BIT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= RESET_VAL;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/d_using_tff.sv
// D register built from T flip-flops: each bit toggles when d differs from q,
// so q follows d one clock later.
module d_using_tff
   import d_using_tff_pkg::*;
#(
   parameter int unsigned       WIDTH     = 1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] t;

   always_comb begin
      t = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         t[i] = toggle_for(d[i], q[i]);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_ff #(
         .RESET_VAL (RESET_VAL[i])
      ) u_t_ff (
         .clk (clk),
         .rst (rst),
         .t   (t[i]),
         .q   (q[i])
      );
   end

endmodule

// File: tb/tb_d_using_tff.sv
// Directed bench for d_using_tff: 1-bit default instance and 8-bit instance with RESET_VAL 8'hA5.
module tb_d_using_tff;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       d1  = 1'b0;
   logic [7:0] d8  = 8'h00;
   logic       q1;
   logic [7:0] q8;

   int unsigned n_run  = 0;
   int unsigned n_fail = 0;

   int alt_vals [6] = '{0, 1, 0, 1, 0, 1};

   always #5 clk = ~clk;

   d_using_tff #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
   ) u_dut1 (
      .clk (clk),
      .rst (rst),
      .d   (d1),
      .q   (q1)
   );

   d_using_tff #(
      .WIDTH     (8),
      .RESET_VAL (8'hA5)
   ) u_dut8 (
      .clk (clk),
      .rst (rst),
      .d   (d8),
      .q   (q8)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5000;
      $display("FAIL watchdog: got timeout expected finish at %0t", $time);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail + 1);
      $fatal(1);
   end

   initial begin
      // reset held across edges with d=1
      rst = 1'b0;
      d1  = 1'b1;
      d8  = 8'h3C;
      #1;
      check("rst_async_q1", {7'b0, q1}, 8'h00);
      check("rst_async_q8", q8, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_hold_q1", {7'b0, q1}, 8'h00);
         check("rst_hold_q8", q8, 8'hA5);
      end

      // release changes nothing until the next edge
      rst = 1'b1;
      #1;
      check("release_q1", {7'b0, q1}, 8'h00);
      check("release_q8", q8, 8'hA5);
      tick();
      check("first_cap_q1", {7'b0, q1}, 8'h01);
      check("first_cap_q8", q8, 8'h3C);
      d8 = 8'hFF;
      tick();
      check("cap_ff_q8", q8, 8'hFF);

      // alternating data: every edge toggles
      for (int i = 0; i < 6; i++) begin
         d1 = alt_vals[i][0];
         #1;
         check("alt_t", {7'b0, u_dut1.t}, 8'h01);
         tick();
         check("alt_q", {7'b0, q1}, {7'b0, alt_vals[i][0]});
      end

      // hold: d equals q, no toggles
      d1 = 1'b1;
      d8 = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("hold_t1", {7'b0, u_dut1.t}, 8'h00);
         check("hold_t8", u_dut8.t, 8'h00);
         tick();
         check("hold_q1", {7'b0, q1}, 8'h01);
      end

      // asynchronous reset between edges
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_q1", {7'b0, q1}, 8'h00);
      check("mid_rst_q8", q8, 8'hA5);
      tick();
      check("mid_rst_edge_q1", {7'b0, q1}, 8'h00);
      rst = 1'b1;
      d1  = 1'b1;
      d8  = 8'h5A;
      tick();
      check("mid_rel_q1", {7'b0, q1}, 8'h01);
      check("mid_rel_q8", q8, 8'h5A);

      // reset falling on the same timestep as a rising edge
      d1 = 1'b1;
      d8 = 8'h3C;
      @(posedge clk);
      rst = 1'b0;
      #1;
      check("coinc_q1", {7'b0, q1}, 8'h00);
      check("coinc_q8", q8, 8'hA5);
      #2;
      rst = 1'b1;
      tick();
      check("coinc_rel_q1", {7'b0, q1}, 8'h01);
      check("coinc_rel_q8", q8, 8'h3C);

      d1 = 1'b0;
      d8 = 8'h00;
      tick();
      check("zero_q1", {7'b0, q1}, 8'h00);
      check("zero_q8", q8, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
